// File: rtl/exception_sequencer_pkg.sv
// Shared coprocessor-0 definitions used by the exception sequencer.
//   - ExcCode constants written into Cause.ExcCode
//   - state_t: exception sequencer FSM states
//   - DEFAULT_EXCEPTION_VECTOR: general exception entry point (BEV=1)
package coprocessor0_params;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam logic [31:0] DEFAULT_EXCEPTION_VECTOR = 32'hbfc00380;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_COMMIT   = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

endpackage

// File: rtl/exception_sequencer.sv
// Exception sequencer: takes an interrupt, synchronous exception or ERET from
// the WB stage and walks it through COMMIT -> FLUSH -> REDIRECT.
//
// Ports
//   clock, reset            sole clock; synchronous active-high reset
//   wb_*                    retiring instruction and its exception/ERET info
//   cp0_status_*, cp0_cause_ip, cp0_epc   current CP0 state
//   cp0_exception_valid     one-cycle strobe (COMMIT) with code/address/slot payload
//   cp0_eret_flush          one-cycle strobe (COMMIT) for ERET
//   pipeline_flush          kill IF..WB (COMMIT and FLUSH states)
//   redirect_valid/_pc/_ready   handshake to fetch
//   busy                    high whenever not IDLE
//   debug_state             current FSM state
//
// Redirect handshake: redirect_valid and redirect_pc are held stable from the
// first REDIRECT cycle until the cycle in which redirect_ready is also high;
// that cycle is the transfer and the FSM returns to IDLE on the next edge.
module exception_sequencer
  import coprocessor0_params::*;
#(
  parameter logic [31:0] EXCEPTION_VECTOR = DEFAULT_EXCEPTION_VECTOR,
  parameter int          FLUSH_CYCLES     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [31:0] wb_pc,
  input  logic        wb_in_delay_slot,
  input  logic        wb_exception,
  input  logic [4:0]  wb_exception_code,
  input  logic        wb_eret,
  input  logic        cp0_status_ie,
  input  logic        cp0_status_exl,
  input  logic [7:0]  cp0_status_im,
  input  logic [7:0]  cp0_cause_ip,
  input  logic [31:0] cp0_epc,
  output logic        cp0_exception_valid,
  output logic        cp0_eret_flush,
  output logic [4:0]  cp0_exception_code,
  output logic [31:0] cp0_exception_address,
  output logic        cp0_in_delay_slot,
  output logic        pipeline_flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy,
  output state_t      debug_state
);

  state_t      state_q, state_d;
  logic        is_eret_q, is_eret_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        slot_q, slot_d;
  logic [31:0] target_q, target_d;
  logic [2:0]  count_q, count_d;

  logic interrupt_pending;

  assign interrupt_pending = cp0_status_ie & ~cp0_status_exl &
                             (|(cp0_status_im & cp0_cause_ip));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      is_eret_q <= 1'b0;
      code_q    <= 5'h00;
      pc_q      <= 32'h0;
      slot_q    <= 1'b0;
      target_q  <= 32'h0;
      count_q   <= 3'd0;
    end else begin
      state_q   <= state_d;
      is_eret_q <= is_eret_d;
      code_q    <= code_d;
      pc_q      <= pc_d;
      slot_q    <= slot_d;
      target_q  <= target_d;
      count_q   <= count_d;
    end
  end

  always_comb begin
    state_d               = state_q;
    is_eret_d             = is_eret_q;
    code_d                = code_q;
    pc_d                  = pc_q;
    slot_d                = slot_q;
    target_d              = target_q;
    count_d               = count_q;
    cp0_exception_valid   = 1'b0;
    cp0_eret_flush        = 1'b0;
    cp0_exception_code    = 5'h00;
    cp0_exception_address = 32'h0;
    cp0_in_delay_slot     = 1'b0;
    pipeline_flush        = 1'b0;
    redirect_valid        = 1'b0;
    redirect_pc           = 32'h0;

    unique case (state_q)
      ST_IDLE: begin
        if (wb_valid && (interrupt_pending || wb_exception || wb_eret)) begin
          // Interrupt beats exception beats ERET; interrupt forces code 0.
          is_eret_d = ~interrupt_pending & ~wb_exception;
          code_d    = interrupt_pending ? EXC_INT :
                      (wb_exception ? wb_exception_code : 5'h00);
          pc_d      = wb_pc;
          slot_d    = wb_in_delay_slot;
          state_d   = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        pipeline_flush = 1'b1;
        count_d        = 3'(FLUSH_CYCLES);
        state_d        = ST_FLUSH;
        if (is_eret_q) begin
          cp0_eret_flush = 1'b1;
          target_d       = cp0_epc;
        end else begin
          cp0_exception_valid   = 1'b1;
          cp0_exception_code    = code_q;
          cp0_exception_address = pc_q;
          cp0_in_delay_slot     = slot_q;
          target_d              = EXCEPTION_VECTOR;
        end
      end
      ST_FLUSH: begin
        pipeline_flush = 1'b1;
        count_d        = count_q - 3'd1;
        if (count_q <= 3'd1) begin
          count_d = 3'd0;
          state_d = ST_REDIRECT;
        end
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = target_q;
        if (redirect_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy        = (state_q != ST_IDLE);
  assign debug_state = state_q;

endmodule

// File: tb/tb_exception_sequencer.sv
module tb_exception_sequencer;
  import coprocessor0_params::*;

  localparam int          F   = 2;
  localparam logic [31:0] VEC = 32'hbfc00380;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wb_valid = 1'b0;
  logic [31:0] wb_pc = 32'h0;
  logic        wb_in_delay_slot = 1'b0;
  logic        wb_exception = 1'b0;
  logic [4:0]  wb_exception_code = 5'h0;
  logic        wb_eret = 1'b0;
  logic        cp0_status_ie = 1'b0;
  logic        cp0_status_exl = 1'b0;
  logic [7:0]  cp0_status_im = 8'h0;
  logic [7:0]  cp0_cause_ip = 8'h0;
  logic [31:0] cp0_epc = 32'h0;
  logic        cp0_exception_valid;
  logic        cp0_eret_flush;
  logic [4:0]  cp0_exception_code;
  logic [31:0] cp0_exception_address;
  logic        cp0_in_delay_slot;
  logic        pipeline_flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b1;
  logic        busy;
  state_t      debug_state;

  int n_assert = 0;
  int n_fail   = 0;

  // {eret_flush, exception_valid, code, address, slot}
  logic [39:0] exp_q[$];
  logic [31:0] exp_pc_q[$];

  exception_sequencer #(.EXCEPTION_VECTOR(VEC), .FLUSH_CYCLES(F)) dut (
    .clock(clock), .reset(reset),
    .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_in_delay_slot(wb_in_delay_slot),
    .wb_exception(wb_exception), .wb_exception_code(wb_exception_code),
    .wb_eret(wb_eret),
    .cp0_status_ie(cp0_status_ie), .cp0_status_exl(cp0_status_exl),
    .cp0_status_im(cp0_status_im), .cp0_cause_ip(cp0_cause_ip),
    .cp0_epc(cp0_epc),
    .cp0_exception_valid(cp0_exception_valid), .cp0_eret_flush(cp0_eret_flush),
    .cp0_exception_code(cp0_exception_code),
    .cp0_exception_address(cp0_exception_address),
    .cp0_in_delay_slot(cp0_in_delay_slot),
    .pipeline_flush(pipeline_flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .busy(busy), .debug_state(debug_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  // Advance one rising edge and settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] all_outputs();
    return 80'({cp0_exception_valid, cp0_eret_flush, cp0_exception_code,
                cp0_exception_address, cp0_in_delay_slot, pipeline_flush,
                redirect_valid, redirect_pc, busy});
  endfunction

  // driver tasks
  task automatic clear_wb();
    wb_valid = 1'b0; wb_exception = 1'b0; wb_eret = 1'b0;
    wb_in_delay_slot = 1'b0; wb_exception_code = 5'h0; wb_pc = 32'h0;
  endtask

  task automatic drive_exc(input logic [4:0] code, input logic [31:0] pc, input logic slot);
    wb_valid = 1'b1; wb_exception = 1'b1; wb_exception_code = code;
    wb_pc = pc; wb_in_delay_slot = slot;
  endtask

  // Expected-value model for a taken event.
  task automatic expect_event(input logic [31:0] pc, input logic slot);
    logic intr;
    intr = cp0_status_ie & ~cp0_status_exl & (|(cp0_status_im & cp0_cause_ip));
    if (intr)
      begin exp_q.push_back({2'b01, 5'h00, pc, slot}); exp_pc_q.push_back(VEC); end
    else if (wb_exception)
      begin exp_q.push_back({2'b01, wb_exception_code, pc, slot}); exp_pc_q.push_back(VEC); end
    else
      begin exp_q.push_back({2'b10, 5'h00, 32'h0, 1'b0}); exp_pc_q.push_back(cp0_epc); end
  endtask

  // Walk one event from the capture edge through the redirect handshake,
  // checking every cycle; stall = cycles redirect_ready is held low.
  task automatic run_event(input string tag, input int stall);
    logic [39:0] e;
    logic [31:0] p;
    redirect_ready = (stall == 0);
    step();
    clear_wb();
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 80'd0, 80'd1);
      return;
    end
    e = exp_q.pop_front();
    p = exp_pc_q.pop_front();
    chk({tag, "_commit"}, 80'({cp0_eret_flush, cp0_exception_valid, cp0_exception_code,
                                cp0_exception_address, cp0_in_delay_slot}), 80'(e));
    chk({tag, "_commit_flush"}, 80'({pipeline_flush, busy, redirect_valid}), 80'(3'b110));
    for (int i = 0; i < F; i++) begin
      step();
      chk({tag, "_flush"}, 80'({pipeline_flush, cp0_exception_valid, cp0_eret_flush,
                                 redirect_valid, busy}), 80'(5'b10001));
    end
    step();
    chk({tag, "_redirect"}, 80'({redirect_valid, redirect_pc, pipeline_flush, busy}),
        80'({1'b1, p, 1'b0, 1'b1}));
    for (int i = 0; i < stall; i++) begin
      drive_exc(5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)));
      step();
      chk({tag, "_stall"}, 80'({redirect_valid, redirect_pc, busy, cp0_exception_valid,
                                 pipeline_flush}), 80'({1'b1, p, 1'b1, 1'b0, 1'b0}));
    end
    clear_wb();
    redirect_ready = 1'b1;
    step();
    chk({tag, "_idle"}, all_outputs(), 80'd0);
    chk({tag, "_state"}, 80'(debug_state), 80'(ST_IDLE));
  endtask

  initial begin
    // reset
    reset = 1'b1;
    step(); step();
    chk("reset_outputs", all_outputs(), 80'd0);
    reset = 1'b0;
    step();
    chk("post_reset_idle", 80'({busy, debug_state}), 80'(3'b000));

    // synchronous exception, Sys
    drive_exc(EXC_SYS, 32'hbfc00100, 1'b0);
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("sys", 0);

    // interrupt overrides same-instruction Ov exception
    cp0_status_ie = 1'b1; cp0_status_exl = 1'b0;
    cp0_status_im = 8'h80; cp0_cause_ip = 8'h80;
    drive_exc(EXC_OV, 32'hbfc00140, 1'b0);
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("intr", 0);

    // interrupt pending but no WB instruction: nothing taken
    step(); step();
    chk("intr_no_wb_valid", 80'({busy, pipeline_flush, cp0_exception_valid}), 80'd0);
    cp0_cause_ip = 8'h00;

    // ERET with EPC capture
    cp0_epc = 32'hbfc00200;
    wb_valid = 1'b1; wb_eret = 1'b1; wb_pc = 32'hbfc00180;
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("eret", 0);

    // ERET plus exception is handled as the exception
    drive_exc(EXC_RI, 32'hbfc00190, 1'b0);
    wb_eret = 1'b1;
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("eret_exc", 0);

    // stalled redirect, WB exception pulses ignored
    drive_exc(EXC_BP, 32'hbfc00300, 1'b0);
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("stall", 5);

    // EXL blocks interrupt; delay-slot exception committed
    cp0_status_ie = 1'b1; cp0_status_exl = 1'b1;
    cp0_status_im = 8'h04; cp0_cause_ip = 8'h04;
    drive_exc(EXC_ADEL, 32'hbfc00404, 1'b1);
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("exl_slot", 0);
    cp0_status_exl = 1'b0; cp0_status_ie = 1'b0; cp0_cause_ip = 8'h00;

    // reset during FLUSH aborts the event
    drive_exc(EXC_ADES, 32'hbfc00500, 1'b0);
    step();
    clear_wb();
    chk("rst_commit_seen", 80'(cp0_exception_valid), 80'd1);
    step();
    chk("rst_in_flush", 80'(debug_state), 80'(ST_FLUSH));
    reset = 1'b1;
    step();
    chk("rst_flush_outputs", all_outputs(), 80'd0);
    chk("rst_flush_state", 80'(debug_state), 80'(ST_IDLE));
    reset = 1'b0;
    step();
    chk("rst_flush_stays_idle", all_outputs(), 80'd0);

    // new exception after reset sequences normally
    drive_exc(EXC_OV, 32'hbfc00600, 1'b0);
    expect_event(wb_pc, wb_in_delay_slot);
    run_event("after_rst", 0);

    // event in reset cycle is dropped
    reset = 1'b1;
    drive_exc(EXC_SYS, 32'hbfc00700, 1'b0);
    step();
    reset = 1'b0;
    clear_wb();
    step();
    chk("rst_drops_event", all_outputs(), 80'd0);

    // random exceptions with random stalls
    for (int k = 0; k < 4; k++) begin
      drive_exc(5'($urandom_range(1, 31)), {$urandom_range(0, 32'h3fff_ffff), 2'b00},
                1'($urandom_range(0, 1)));
      expect_event(wb_pc, wb_in_delay_slot);
      run_event("rand", $urandom_range(0, 3));
    end

    chk("sb_drained", 80'(exp_q.size() + exp_pc_q.size()), 80'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
